// File: rtl/mips_mem_responder.sv
// Instruction/data memory responder for the single-cycle core, with a boot-load FSM that fills
// IMEM from a valid/ready stream before releasing core reset. MEM_STATS_EN adds access counters.
module mips_mem_responder #(
    parameter int unsigned IMEM_DEPTH = 256,
    parameter int unsigned DMEM_DEPTH = 256,
    parameter int unsigned BOOT_LOAD  = 1
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [31:0] pc,
    output logic [31:0] inst,
    input  logic [31:0] mem_daddr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_we,
    input  logic        mem_re,
    output logic [31:0] mem_rdata,
    input  logic        ld_valid,
    input  logic [31:0] ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        core_nrst,
`ifdef MEM_STATS_EN
    output logic [31:0] load_cnt,
    output logic [31:0] store_cnt,
`endif
    output logic        misalign_err,
    output logic        range_err
);

    typedef enum logic [0:0] {StLoad, StRun} state_e;

    localparam int unsigned IMEM_AW = $clog2(IMEM_DEPTH);
    localparam int unsigned DMEM_AW = $clog2(DMEM_DEPTH);
    localparam state_e      RESET_STATE = (BOOT_LOAD != 0) ? StLoad : StRun;
    localparam logic [IMEM_AW:0] PTR_ONE = 1;

    logic [31:0] r_imem [IMEM_DEPTH];
    logic [31:0] r_dmem [DMEM_DEPTH];

    state_e             r_state;
    state_e             w_state_next;
    logic [IMEM_AW:0]   r_ptr;
    logic [IMEM_AW:0]   w_ptr_next;
    logic               r_ld_ready;
    logic               r_core_nrst;
    logic               r_misalign_err;
    logic               r_range_err;

    logic               w_run;
    logic               w_ld_fire;
    logic               w_ld_wr;
    logic               w_ld_drop;
    logic               w_pc_mis;
    logic               w_pc_oor;
    logic               w_pc_ok;
    logic [IMEM_AW-1:0] w_iidx;
    logic               w_d_access;
    logic               w_d_mis;
    logic               w_d_oor;
    logic               w_d_ok;
    logic [DMEM_AW-1:0] w_didx;
    logic               w_load_ok;
    logic               w_store_ok;
    logic               w_mis_set;
    logic               w_oor_set;

    assign w_run     = (r_state == StRun);
    assign w_ld_fire = r_ld_ready & ld_valid;

    // Pointer saturates at IMEM_DEPTH; its MSB then marks every further word as overflow.
    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_ld_wr      = 1'b0;
        w_ld_drop    = 1'b0;
        if (r_state == StLoad && w_ld_fire) begin
            w_ld_wr   = ~r_ptr[IMEM_AW];
            w_ld_drop = r_ptr[IMEM_AW];
            if (!r_ptr[IMEM_AW]) begin
                w_ptr_next = r_ptr + PTR_ONE;
            end
            if (ld_last) begin
                w_state_next = StRun;
            end
        end
    end

    assign w_pc_mis = |pc[1:0];
    assign w_pc_oor = |pc[31:IMEM_AW+2];
    assign w_pc_ok  = ~w_pc_mis & ~w_pc_oor;
    assign w_iidx   = pc[IMEM_AW+1:2];
    assign inst     = (w_run && w_pc_ok) ? r_imem[w_iidx] : 32'h0000_0000;

    assign w_d_access = mem_re | mem_we;
    assign w_d_mis    = |mem_daddr[1:0];
    assign w_d_oor    = |mem_daddr[31:DMEM_AW+2];
    assign w_d_ok     = ~w_d_mis & ~w_d_oor;
    assign w_didx     = mem_daddr[DMEM_AW+1:2];
    assign w_load_ok  = w_run & mem_re & w_d_ok;
    assign w_store_ok = w_run & mem_we & w_d_ok;
    assign mem_rdata  = w_load_ok ? r_dmem[w_didx] : 32'h0000_0000;

    // Core-port faults only count once the core is running; overflowed boot words always count.
    assign w_mis_set = w_run & (w_pc_mis | (w_d_access & w_d_mis));
    assign w_oor_set = (w_run & (w_pc_oor | (w_d_access & w_d_oor))) | w_ld_drop;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state        <= RESET_STATE;
            r_ptr          <= '0;
            r_ld_ready     <= 1'b0;
            r_core_nrst    <= 1'b0;
            r_misalign_err <= 1'b0;
            r_range_err    <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_ptr          <= w_ptr_next;
            r_ld_ready     <= (w_state_next == StLoad);
            r_core_nrst    <= (w_state_next == StRun);
            r_misalign_err <= r_misalign_err | w_mis_set;
            r_range_err    <= r_range_err | w_oor_set;
        end
    end

    // Memory arrays carry no reset so they survive nrst.
    always_ff @(posedge clk) begin
        if (w_ld_wr) begin
            r_imem[r_ptr[IMEM_AW-1:0]] <= ld_data;
        end
        if (w_store_ok) begin
            r_dmem[w_didx] <= mem_wdata;
        end
    end

    assign ld_ready     = r_ld_ready;
    assign core_nrst    = r_core_nrst;
    assign misalign_err = r_misalign_err;
    assign range_err    = r_range_err;

`ifdef MEM_STATS_EN
    logic [31:0] r_load_cnt;
    logic [31:0] r_store_cnt;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_load_cnt  <= 32'd0;
            r_store_cnt <= 32'd0;
        end else begin
            if (w_load_ok && (r_load_cnt != 32'hFFFF_FFFF)) begin
                r_load_cnt <= r_load_cnt + 32'd1;
            end
            if (w_store_ok && (r_store_cnt != 32'hFFFF_FFFF)) begin
                r_store_cnt <= r_store_cnt + 32'd1;
            end
        end
    end

    assign load_cnt  = r_load_cnt;
    assign store_cnt = r_store_cnt;
`endif

endmodule

// File: tb/tb_mips_mem_responder.sv
// Randomized bench for mips_mem_responder against a word-level memory/flag reference model.
module tb_mips_mem_responder;

    localparam int unsigned IMEM_DEPTH = 256;
    localparam int unsigned DMEM_DEPTH = 256;
    localparam int unsigned BOOT_LOAD  = 1;

    logic        clk = 1'b0;
    logic        nrst;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] mem_daddr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic        core_nrst;
    logic        misalign_err;
    logic        range_err;
`ifdef MEM_STATS_EN
    logic [31:0] load_cnt;
    logic [31:0] store_cnt;
`endif

    always #5 clk = ~clk;

    mips_mem_responder #(
        .IMEM_DEPTH(IMEM_DEPTH),
        .DMEM_DEPTH(DMEM_DEPTH),
        .BOOT_LOAD (BOOT_LOAD)
    ) u_dut (
        .clk         (clk),
        .nrst        (nrst),
        .pc          (pc),
        .inst        (inst),
        .mem_daddr   (mem_daddr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_re      (mem_re),
        .mem_rdata   (mem_rdata),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .ld_ready    (ld_ready),
        .core_nrst   (core_nrst),
`ifdef MEM_STATS_EN
        .load_cnt    (load_cnt),
        .store_cnt   (store_cnt),
`endif
        .misalign_err(misalign_err),
        .range_err   (range_err)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit          m_run;
    bit          m_rdy;
    bit          m_cnrst;
    bit          m_mis;
    bit          m_oor;
    int          m_ptr;
    logic [31:0] m_imem [IMEM_DEPTH];
    bit          m_iv   [IMEM_DEPTH];
    logic [31:0] m_dmem [DMEM_DEPTH];
    bit          m_dv   [DMEM_DEPTH];
`ifdef MEM_STATS_EN
    longint unsigned m_lcnt;
    longint unsigned m_scnt;
`endif
    logic [31:0] q_ld [$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit addr_ok(input logic [31:0] a, input int unsigned depth);
        return (a[1:0] == 2'b00) && (64'(a) < 64'(depth) * 64'd4);
    endfunction

    task automatic model_reset();
        m_run   = (BOOT_LOAD == 0);
        m_rdy   = 1'b0;
        m_cnrst = 1'b0;
        m_mis   = 1'b0;
        m_oor   = 1'b0;
        m_ptr   = 0;
`ifdef MEM_STATS_EN
        m_lcnt  = 0;
        m_scnt  = 0;
`endif
    endtask

    task automatic settle();
        int idx;
        @(negedge clk);
        if (!nrst) model_reset();
        check_eq("ld_ready", 32'(ld_ready), 32'(m_rdy));
        check_eq("core_nrst", 32'(core_nrst), 32'(m_cnrst));
        check_eq("misalign_err", 32'(misalign_err), 32'(m_mis));
        check_eq("range_err", 32'(range_err), 32'(m_oor));
        if (!m_run || !addr_ok(pc, IMEM_DEPTH)) begin
            check_eq("inst_zero", inst, 32'h0);
        end else begin
            idx = int'(pc >> 2);
            if (m_iv[idx]) check_eq("inst", inst, m_imem[idx]);
        end
        if (!m_run || !mem_re || !addr_ok(mem_daddr, DMEM_DEPTH)) begin
            check_eq("rdata_zero", mem_rdata, 32'h0);
        end else begin
            idx = int'(mem_daddr >> 2);
            if (m_dv[idx]) check_eq("rdata", mem_rdata, m_dmem[idx]);
        end
`ifdef MEM_STATS_EN
        check_eq("load_cnt", load_cnt, 32'(m_lcnt));
        check_eq("store_cnt", store_cnt, 32'(m_scnt));
`endif
    endtask

    task automatic advance();
        int idx;
        @(posedge clk);
        if (!nrst) begin
            model_reset();
        end else if (!m_run) begin
            if (ld_valid && m_rdy) begin
                if (m_ptr < int'(IMEM_DEPTH)) begin
                    m_imem[m_ptr] = ld_data;
                    m_iv[m_ptr]   = 1'b1;
                end else begin
                    m_oor = 1'b1;
                end
                m_ptr++;
                if (ld_last) m_run = 1'b1;
            end
            m_rdy   = !m_run;
            m_cnrst = m_run;
        end else begin
            if (pc[1:0] != 2'b00) m_mis = 1'b1;
            if (64'(pc) >= 64'(IMEM_DEPTH) * 64'd4) m_oor = 1'b1;
            if (mem_re || mem_we) begin
                if (mem_daddr[1:0] != 2'b00) m_mis = 1'b1;
                if (64'(mem_daddr) >= 64'(DMEM_DEPTH) * 64'd4) m_oor = 1'b1;
                if (addr_ok(mem_daddr, DMEM_DEPTH)) begin
                    idx = int'(mem_daddr >> 2);
                    if (mem_we) begin
                        m_dmem[idx] = mem_wdata;
                        m_dv[idx]   = 1'b1;
                    end
`ifdef MEM_STATS_EN
                    if (mem_we && m_scnt < 64'hFFFF_FFFF) m_scnt++;
                    if (mem_re && m_lcnt < 64'hFFFF_FFFF) m_lcnt++;
`endif
                end
            end
            m_rdy   = 1'b0;
            m_cnrst = 1'b1;
        end
        #1;
    endtask

    task automatic step();
        settle();
        advance();
    endtask

    task automatic drive_idle();
        pc        = 32'h0;
        mem_daddr = 32'h0;
        mem_wdata = 32'h0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        ld_valid  = 1'b0;
        ld_data   = 32'h0;
        ld_last   = 1'b0;
    endtask

    task automatic drive_core_random(input bit allow_bad);
        pc        = 32'($urandom_range(0, 63)) << 2;
        mem_daddr = 32'($urandom_range(0, 15)) << 2;
        if (allow_bad && $urandom_range(0, 15) == 0) pc = $urandom();
        if (allow_bad && $urandom_range(0, 15) == 0) mem_daddr = $urandom();
        mem_wdata = $urandom();
        mem_we    = 1'($urandom_range(0, 1));
        mem_re    = 1'($urandom_range(0, 1));
        ld_valid  = 1'($urandom_range(0, 1));
        ld_data   = $urandom();
        ld_last   = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        drive_idle();
        nrst = 1'b0;
        model_reset();
        repeat (2) step();
        nrst = 1'b1;
    endtask

    // Streams n words with random valid gaps; core ports carry junk that LOAD must ignore.
    task automatic load_stream(input int n, input bit with_last);
        int  sent;
        bit  acc;
        sent = 0;
        q_ld.delete();
        while (sent < n) begin
            drive_core_random(1'b1);
            ld_valid = ($urandom_range(0, 3) != 0);
            ld_data  = $urandom();
            ld_last  = with_last && (sent == n - 1);
            settle();
            acc = ld_valid && m_rdy;
            if (acc) begin
                q_ld.push_back(ld_data);
                sent++;
            end
            advance();
        end
        drive_idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] boot [3];
        int          i;
        bit          acc;
        boot[0] = 32'h2008_0005;
        boot[1] = 32'h2009_0007;
        boot[2] = 32'h0000_0000;

        drive_idle();
        nrst = 1'b0;
        model_reset();
        do_reset();

        // Boot load of three words; valid is held from the first cycle out of reset.
        i = 0;
        while (i < 3) begin
            ld_valid  = 1'b1;
            ld_data   = boot[i];
            ld_last   = (i == 2);
            pc        = 32'h2;
            mem_we    = 1'b1;
            mem_daddr = 32'h401;
            settle();
            check_eq("boot_core_held", 32'(core_nrst), 32'h0);
            acc = m_rdy;
            advance();
            if (acc) i++;
        end
        drive_idle();
        pc = 32'h4;
        settle();
        check_eq("boot_core_released", 32'(core_nrst), 32'h1);
        check_eq("boot_inst_pc4", inst, 32'h2009_0007);
        advance();

        // Store then load, and read-before-write on a same-cycle collision.
        drive_idle(); mem_we = 1'b1; mem_daddr = 32'h10; mem_wdata = 32'hDEAD_BEEF;
        step();
        drive_idle(); mem_re = 1'b1; mem_daddr = 32'h10;
        settle(); check_eq("st_then_ld", mem_rdata, 32'hDEAD_BEEF); advance();
        mem_we = 1'b1; mem_wdata = 32'h1234_5678;
        settle(); check_eq("st_ld_same_old", mem_rdata, 32'hDEAD_BEEF); advance();
        drive_idle(); mem_re = 1'b1; mem_daddr = 32'h10;
        settle(); check_eq("st_ld_same_new", mem_rdata, 32'h1234_5678); advance();

        // Misaligned store is suppressed and raises a sticky flag.
        drive_idle(); mem_we = 1'b1; mem_daddr = 32'h13; mem_wdata = 32'hBAD0_BAD0;
        settle(); check_eq("mis_before", 32'(misalign_err), 32'h0); advance();
        drive_idle(); mem_re = 1'b1; mem_daddr = 32'h10;
        settle();
        check_eq("mis_after", 32'(misalign_err), 32'h1);
        check_eq("mis_no_store", mem_rdata, 32'h1234_5678);
        advance();

        // Out-of-range load and fetch.
        drive_idle(); mem_re = 1'b1; mem_daddr = 32'h400;
        settle();
        check_eq("oor_rdata", mem_rdata, 32'h0);
        check_eq("oor_before", 32'(range_err), 32'h0);
        advance();
        drive_idle(); pc = 32'h8000_0000;
        settle();
        check_eq("oor_after", 32'(range_err), 32'h1);
        check_eq("oor_inst", inst, 32'h0);
        advance();
        drive_idle();
        repeat (4) step();
        settle();
        check_eq("mis_sticky", 32'(misalign_err), 32'h1);
        advance();

        // Reset in the middle of a load, then reload from IMEM[0].
        do_reset();
        load_stream(2, 1'b0);
        #2;
        check_eq("ready_before_rst", 32'(ld_ready), 32'h1);
        nrst = 1'b0;
        #1;
        check_eq("async_rst_ready", 32'(ld_ready), 32'h0);
        check_eq("async_rst_core", 32'(core_nrst), 32'h0);
        model_reset();
        repeat (2) step();
        nrst = 1'b1;
        load_stream(40, 1'b1);
        pc = 32'h0;
        settle(); check_eq("reload_imem0", inst, q_ld[0]); advance();

        // Random traffic: well-formed first, then with occasional bad addresses.
        repeat (300) begin
            drive_core_random(1'b0);
            step();
        end
        repeat (100) begin
            drive_core_random(1'b1);
            step();
        end

        // Counted accesses: 5 loads, 3 stores, 1 misaligned store.
        do_reset();
        load_stream(1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            drive_idle(); mem_we = 1'b1; mem_daddr = 32'h20 + 32'(k * 4); mem_wdata = $urandom();
            step();
        end
        drive_idle(); mem_we = 1'b1; mem_daddr = 32'h21; mem_wdata = $urandom();
        step();
        for (int k = 0; k < 5; k++) begin
            drive_idle(); mem_re = 1'b1; mem_daddr = 32'h20 + 32'((k % 3) * 4);
            step();
        end
        drive_idle();
        settle();
`ifdef MEM_STATS_EN
        check_eq("stats_load", load_cnt, 32'd5);
        check_eq("stats_store", store_cnt, 32'd3);
`endif
        check_eq("stats_mis", 32'(misalign_err), 32'h1);
        advance();

        // Overflow: two words beyond IMEM are dropped but the load still completes.
        do_reset();
        load_stream(int'(IMEM_DEPTH) + 2, 1'b1);
        pc = 32'((IMEM_DEPTH - 1) * 4);
        settle();
        check_eq("ovf_range", 32'(range_err), 32'h1);
        check_eq("ovf_run", 32'(core_nrst), 32'h1);
        check_eq("ovf_last_kept", inst, q_ld[IMEM_DEPTH-1]);
        advance();
        drive_idle();
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
